sn74ls259s: RTL and testbench

SN74LS259S -- requirements
Module: sn74ls259s

---
 rtl/sn74ls259s.sv | 121 ++++++++++++
 tb/tb_sn74ls259s.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sn74ls259s.sv
// sn74ls259s: 8-bit addressable latch / 1-of-8 demultiplexer with an optional
// internal scan pointer that walks the address 0..7 and flags a complete frame.
//
// Build option: define SN74LS259S_SCAN_EN to enable the scan input, the scan
// pointer p and the frame-complete strobe f. With it undefined, scan is
// ignored, the address always comes from {c,b,a}, and p and f read 0.
//
// tCQ_min/tCQ_typ/tCQ_max record the device clock-to-output timing in ns.
// The RTL output itself is zero-delay; the values are only sanity-checked
// at elaboration so an inconsistent override is caught early.
module sn74ls259s #(
    parameter int tCQ_min = 0,
    parameter int tCQ_typ = 18,
    parameter int tCQ_max = 27
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       g,
    input  logic       m,
    input  logic       d,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       scan,
    output logic [7:0] q,
    output logic       w,
    output logic       f,
    output logic [2:0] p
);

    // Reject a delay triple that is not ordered min <= typ <= max.
    if (!((tCQ_min <= tCQ_typ) && (tCQ_typ <= tCQ_max))) begin : g_bad_tcq
        $error("sn74ls259s: tCQ parameters must satisfy min <= typ <= max");
    end

    logic [2:0] sel;     // external address, c is the MSB
    logic [2:0] addr;    // effective address for writes and for w
    logic       scan_act;
    logic [7:0] q_nxt;

    assign sel = {c, b, a};

`ifdef SN74LS259S_SCAN_EN
    logic [2:0] p_r;
    logic       f_r;
    logic [2:0] p_nxt;
    logic       f_nxt;

    assign scan_act = scan;
    assign p        = p_r;
    assign f        = f_r;
`else
    // Scan feature absent: the input is accepted but has no effect.
    logic unused_scan;

    assign unused_scan = scan;
    assign scan_act    = 1'b0;
    assign p           = 3'b000;
    assign f           = 1'b0;
`endif

    // Select the address source: scan pointer while scanning, else {c,b,a}.
    always_comb begin
        addr = sel;
`ifdef SN74LS259S_SCAN_EN
        if (scan_act) begin
            addr = p_r;
        end
`endif
    end

    // Next latch contents: hold when g is high, otherwise latch or demux write.
    always_comb begin
        q_nxt = q;
        if (!g) begin
            if (m) begin
                q_nxt = 8'h00;
            end
            q_nxt[addr] = d;
        end
    end

`ifdef SN74LS259S_SCAN_EN
    // Next pointer and strobe: advance on every enabled scan write; the
    // strobe marks the write to the last slot of a frame for one cycle only.
    always_comb begin
        p_nxt = p_r;
        f_nxt = 1'b0;
        if (!g && scan_act) begin
            p_nxt = p_r + 3'd1;
            f_nxt = (p_r == 3'd7);
        end
    end

    // Pointer and strobe registers; clr restarts the frame with no strobe.
    always_ff @(posedge clk) begin
        if (clr) begin
            p_r <= 3'b000;
            f_r <= 1'b0;
        end else begin
            p_r <= p_nxt;
            f_r <= f_nxt;
        end
    end
`endif

    // Latch register; clr wins over every other input.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= 8'h00;
        end else begin
            q <= q_nxt;
        end
    end

    // w is the inverted latch bit at the currently effective address.
    always_comb begin
        w = ~q[addr];
    end

endmodule

// File: tb/tb_sn74ls259s.sv
// Scoreboard bench for sn74ls259s: stimulus pushes expected state into a
// queue at each falling edge; a monitor pops and compares after each rising
// edge. Directed sequences additionally attach fixed expected values.
module tb_sn74ls259s;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       g = 1'b1;
    logic       m = 1'b0;
    logic       d = 1'b0;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic       c = 1'b0;
    logic       scan = 1'b0;
    logic [7:0] q;
    logic       w;
    logic       f;
    logic [2:0] p;

`ifdef SN74LS259S_SCAN_EN
    localparam bit SCAN_EN = 1'b1;
`else
    localparam bit SCAN_EN = 1'b0;
`endif

    sn74ls259s dut (
        .clk (clk),
        .clr (clr),
        .g   (g),
        .m   (m),
        .d   (d),
        .a   (a),
        .b   (b),
        .c   (c),
        .scan(scan),
        .q   (q),
        .w   (w),
        .f   (f),
        .p   (p)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [2:0] p;
        logic       f;
        logic       w;
        bit         cq_en;
        logic [7:0] cq;
        bit         cw_en;
        logic       cw;
        bit         cf_en;
        logic       cf;
        bit         cp_en;
        logic [2:0] cp;
    } exp_t;

    exp_t sb[$];

    int assertions = 0;
    int failures   = 0;

    // Reference state: eight independent storage bits, a frame position and
    // a "just finished a frame" flag.
    bit mq[8];
    int mpos = 0;
    bit mfrm = 1'b0;

    function automatic logic [7:0] pack_q();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = mq[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        assertions++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Apply one clock of stimulus and record what the device must show after it.
    task automatic step(input bit i_clr, input bit i_g, input bit i_m, input bit i_d,
                        input int i_addr, input bit i_scan);
        exp_t e;
        int   eff;
        bool_scan: begin end
        @(negedge clk);
        clr  = i_clr;
        g    = i_g;
        m    = i_m;
        d    = i_d;
        a    = i_addr[0];
        b    = i_addr[1];
        c    = i_addr[2];
        scan = i_scan;

        eff = (SCAN_EN && i_scan) ? mpos : (i_addr % 8);
        if (i_clr) begin
            for (int i = 0; i < 8; i++) mq[i] = 1'b0;
            mpos = 0;
            mfrm = 1'b0;
        end else if (i_g) begin
            mfrm = 1'b0;
        end else begin
            if (i_m) for (int i = 0; i < 8; i++) mq[i] = 1'b0;
            mq[eff] = i_d;
            mfrm = SCAN_EN && i_scan && (eff == 7);
            if (SCAN_EN && i_scan) mpos = (mpos + 1) % 8;
        end

        eff     = (SCAN_EN && i_scan) ? mpos : (i_addr % 8);
        e.q     = pack_q();
        e.p     = 3'(mpos);
        e.f     = mfrm;
        e.w     = !mq[eff];
        e.cq_en = 1'b0;
        e.cq    = 8'h00;
        e.cw_en = 1'b0;
        e.cw    = 1'b0;
        e.cf_en = 1'b0;
        e.cf    = 1'b0;
        e.cp_en = 1'b0;
        e.cp    = 3'b000;
        sb.push_back(e);
    endtask

    // Attach fixed expected values to the most recently issued step.
    task automatic want_q(input logic [7:0] v);
        sb[sb.size() - 1].cq_en = 1'b1;
        sb[sb.size() - 1].cq    = v;
    endtask

    task automatic want_w(input logic v);
        sb[sb.size() - 1].cw_en = 1'b1;
        sb[sb.size() - 1].cw    = v;
    endtask

    task automatic want_f(input logic v);
        sb[sb.size() - 1].cf_en = 1'b1;
        sb[sb.size() - 1].cf    = v;
    endtask

    task automatic want_p(input logic [2:0] v);
        sb[sb.size() - 1].cp_en = 1'b1;
        sb[sb.size() - 1].cp    = v;
    endtask

    // Monitor: after every rising edge, compare against the oldest expectation.
    exp_t me;
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            me = sb.pop_front();
            chk("q", q, me.q);
            chk("p", {5'b0, p}, {5'b0, me.p});
            chk("f", {7'b0, f}, {7'b0, me.f});
            chk("w", {7'b0, w}, {7'b0, me.w});
            if (me.cq_en) chk("q_fixed", q, me.cq);
            if (me.cw_en) chk("w_fixed", {7'b0, w}, {7'b0, me.cw});
            if (me.cf_en) chk("f_fixed", {7'b0, f}, {7'b0, me.cf});
            if (me.cp_en) chk("p_fixed", {5'b0, p}, {5'b0, me.cp});
        end
    end

    initial begin
        bit stream[8];
        int budget;
        stream = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset from an all-ones latch.
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, i, 0);
        want_q(8'hFF);
        step(1, 0, 1, 1, 5, 1);
        want_q(8'h00); want_w(1'b1); want_f(1'b0); want_p(3'd0);

        // Latch-mode writes.
        step(0, 0, 0, 1, 2, 0); want_q(8'h04);
        step(0, 0, 0, 1, 5, 0); want_q(8'h24);
        step(0, 0, 0, 0, 2, 0); want_q(8'h20);
        step(0, 1, 0, 1, 5, 0); want_q(8'h20); want_w(1'b0);

        // Demux-mode writes.
        step(0, 0, 1, 1, 6, 0); want_q(8'h40); want_w(1'b0);
        step(0, 0, 1, 0, 3, 0); want_q(8'h00); want_w(1'b1);

        // Hold with changing inputs.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 3, 0);
        step(0, 0, 0, 1, 4, 0);
        step(0, 0, 0, 1, 6, 0); want_q(8'h5A);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, i % 2, i % 2, (i * 3 + 2) % 8, i % 2);
            want_q(8'h5A); want_p(3'd0);
        end

`ifdef SN74LS259S_SCAN_EN
        // Full scan frame.
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, stream[i], 7 - i, 1);
            if (i < 7) want_f(1'b0);
        end
        want_q(8'h4D); want_p(3'd0); want_f(1'b1);
        step(0, 1, 0, 0, 0, 1); want_f(1'b0); want_q(8'h4D);

        // Frame cut by clr, then a fresh complete frame of ones.
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 0, 1); want_f(1'b0);
        end
        want_p(3'd4);
        step(1, 0, 0, 1, 0, 1); want_q(8'h00); want_p(3'd0); want_f(1'b0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 1, 0, 1);
            if (i < 7) want_f(1'b0);
        end
        want_q(8'hFF); want_f(1'b1);
        step(0, 0, 0, 1, 0, 0); want_f(1'b0);

        // Scan toggled off mid-frame: pointer holds, then resumes.
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 6, 0); want_p(3'd2);
        step(0, 0, 0, 0, 0, 1); want_p(3'd3);
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                 1'($urandom), 1'($urandom), $urandom_range(0, 7),
                 ($urandom_range(0, 3) != 0));
        end

        // Drain the scoreboard within a bounded number of cycles.
        budget = 0;
        while (sb.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (sb.size() > 0) begin
            assertions++;
            failures++;
            $display("FAIL drain actual=%0d pending required=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
